// File: rtl/click_pkg.sv
// Shared types and sizing helpers for the push-button gesture decoder.
package click_pkg;

    // Per-channel gesture FSM states.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPress1 = 3'd1,
        StHeld   = 3'd2,
        StWait   = 3'd3,
        StLock   = 3'd4
    } click_state_e;

    // Bits needed to count 0 .. max(a, b)-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/click_channel.sv
// One button channel: 2-flop synchroniser, debounce filter and gesture FSM.
module click_channel
    import click_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WAIT_CYCLES     = 16,
    parameter int unsigned LONG_CYCLES     = 32,
    parameter bit          LONG_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    input  logic enable_i,
    output logic level_o,
    output logic single_o,
    output logic double_o,
    output logic long_press_o
);

    localparam int unsigned DcntW = cnt_width(DEBOUNCE_CYCLES, 1);
    localparam int unsigned CntW  = cnt_width(WAIT_CYCLES, LONG_CYCLES);

    localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0]  WaitLast = CntW'(WAIT_CYCLES - 1);
    localparam logic [CntW-1:0]  LongLast = CntW'(LONG_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DcntW-1:0] dcnt_q, dcnt_d;
    logic             rise, fall;

    click_state_e     state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic             long_q, long_d;

    // Synchroniser shift and debounce: level flips after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        sync1_d = button_i;
        sync2_d = sync1_q;
        level_d = level_q;
        dcnt_d  = '0;
        rise    = 1'b0;
        fall    = 1'b0;
        if (sync2_q != level_q) begin
            if (dcnt_q == DcntLast) begin
                // Strobes coincide with the edge that updates level, so the FSM reacts
                // in the same cycle the debounced level changes.
                level_d = sync2_q;
                rise    = sync2_q;
                fall    = ~sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Gesture FSM next state and registered pulse requests.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = StPress1;
                end
            end
            StPress1: begin
                cnt_d = cnt_q + 1'b1;
                if (fall) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else if (LONG_EN && (cnt_q == LongLast)) begin
                    long_d  = 1'b1;
                    state_d = StHeld;
                    cnt_d   = '0;
                end
            end
            StHeld: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A second press beats a simultaneous timeout.
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = StLock;
                    cnt_d    = '0;
                end else if (cnt_q == WaitLast) begin
                    single_d = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                end
            end
            StLock: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (!enable_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            single_d = 1'b0;
            double_d = 1'b0;
            long_d   = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            dcnt_q   <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            dcnt_q   <= dcnt_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
        end
    end

    assign level_o      = level_q;
    assign single_o     = single_q;
    assign double_o     = double_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/click_decoder.sv
// Multi-channel push-button gesture decoder: one independent click_channel per button.
module click_decoder
    import click_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WAIT_CYCLES     = 16,
    parameter int unsigned LONG_CYCLES     = 32,
    parameter bit          LONG_EN         = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] single,
    output logic [CHANNELS-1:0] double,
    output logic [CHANNELS-1:0] long_press
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        click_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .WAIT_CYCLES    (WAIT_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .LONG_EN        (LONG_EN)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .button_i    (button[g]),
            .enable_i    (enable[g]),
            .level_o     (level[g]),
            .single_o    (single[g]),
            .double_o    (double[g]),
            .long_press_o(long_press[g])
        );
    end

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder: default instance plus a LONG_EN=0 instance on shared inputs.
module tb_click_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button = 4'hF;
    logic [3:0] enable = 4'hF;
    logic [3:0] level, single, double, long_press;
    logic [3:0] level_nl, single_nl, double_nl, long_nl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_single[4], n_double[4], n_long[4], n_rise[4], n_fall[4];
    int t_single[4], t_double[4], t_long[4], t_rise[4], t_fall[4];
    int n_single_nl[4], n_double_nl[4], n_long_nl[4], t_single_nl[4];
    int n_multi = 0;
    logic [3:0] lvl_prev = 4'h0;
    logic clr = 1'b0;

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    click_decoder #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .WAIT_CYCLES(16), .LONG_CYCLES(32), .LONG_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .enable(enable),
        .level(level), .single(single), .double(double), .long_press(long_press)
    );

    click_decoder #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .WAIT_CYCLES(16), .LONG_CYCLES(32), .LONG_EN(1'b0)
    ) dut_nl (
        .clk(clk), .rst(rst), .button(button), .enable(enable),
        .level(level_nl), .single(single_nl), .double(double_nl), .long_press(long_nl)
    );

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (clr) begin
            for (int c = 0; c < 4; c++) begin
                n_single[c] = 0; n_double[c] = 0; n_long[c] = 0; n_rise[c] = 0; n_fall[c] = 0;
                t_single[c] = 0; t_double[c] = 0; t_long[c] = 0; t_rise[c] = 0; t_fall[c] = 0;
                n_single_nl[c] = 0; n_double_nl[c] = 0; n_long_nl[c] = 0; t_single_nl[c] = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (single[c])     begin n_single[c]++; t_single[c] = cyc; end
                if (double[c])     begin n_double[c]++; t_double[c] = cyc; end
                if (long_press[c]) begin n_long[c]++;   t_long[c]   = cyc; end
                if (level[c] && !lvl_prev[c]) begin n_rise[c]++; t_rise[c] = cyc; end
                if (!level[c] && lvl_prev[c]) begin n_fall[c]++; t_fall[c] = cyc; end
                if (single_nl[c]) begin n_single_nl[c]++; t_single_nl[c] = cyc; end
                if (double_nl[c]) n_double_nl[c]++;
                if (long_nl[c])   n_long_nl[c]++;
                if ($countones({single[c], double[c], long_press[c]}) > 1) n_multi++;
            end
        end
        lvl_prev = level;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
        step(1);
    endtask

    initial begin
        int tp;

        // Reset with all buttons already held.
        step(3);
        chk("rst_level", level, 0);
        chk("rst_single", single, 0);
        chk("rst_double", double, 0);
        chk("rst_long", long_press, 0);
        rst = 1'b0;
        step(5);
        chk("rst_level_pre_db", level, 0);
        step(1);
        chk("rst_level_post_db", level, 4'hF);
        step(10);
        button = 4'h0;
        step(40);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_single_cnt%0d", c), n_single[c], 1);
            chk($sformatf("rst_long_cnt%0d", c), n_long[c], 0);
        end
        chk("rst_simultaneous", t_single[3] - t_single[0], 0);
        chk("rst_single_delay", t_single[0] - t_fall[0], 16);
        clear();

        // Single click on ch0.
        tp = cyc;
        button[0] = 1'b1;
        step(10);
        button[0] = 1'b0;
        step(40);
        chk("single_rise_lat", t_rise[0] - tp, 6);
        chk("single_cnt", n_single[0], 1);
        chk("single_delay", t_single[0] - t_fall[0], 16);
        chk("single_no_double", n_double[0], 0);
        chk("single_no_long", n_long[0], 0);
        clear();

        // Double click on ch1.
        button[1] = 1'b1; step(4);
        button[1] = 1'b0; step(5);
        button[1] = 1'b1; step(6);
        button[1] = 1'b0; step(40);
        chk("double_rises", n_rise[1], 2);
        chk("double_cnt", n_double[1], 1);
        chk("double_on_rise", t_double[1] - t_rise[1], 0);
        chk("double_no_single", n_single[1], 0);
        chk("double_no_long", n_long[1], 0);
        clear();

        // Long press on ch2.
        button[2] = 1'b1; step(100);
        button[2] = 1'b0; step(40);
        chk("long_cnt", n_long[2], 1);
        chk("long_delay", t_long[2] - t_rise[2], 32);
        chk("long_no_single", n_single[2], 0);
        chk("long_no_double", n_double[2], 0);
        chk("nolong_single_cnt", n_single_nl[2], 1);
        chk("nolong_single_delay", t_single_nl[2] - t_fall[2], 16);
        chk("nolong_no_long", n_long_nl[2], 0);
        chk("nolong_no_double", n_double_nl[2], 0);
        clear();

        // 2-cycle glitches on ch3.
        repeat (3) begin
            button[3] = 1'b1; step(2);
            button[3] = 1'b0; step(2);
        end
        step(20);
        chk("glitch_no_rise", n_rise[3], 0);
        chk("glitch_no_events", n_single[3] + n_double[3] + n_long[3], 0);
        clear();

        // Triple click on ch0: double, then the third click alone is a single.
        repeat (3) begin
            button[0] = 1'b1; step(5);
            button[0] = 1'b0; step(6);
        end
        step(40);
        chk("triple_rises", n_rise[0], 3);
        chk("triple_double", n_double[0], 1);
        chk("triple_single", n_single[0], 1);
        chk("triple_single_delay", t_single[0] - t_fall[0], 16);
        chk("triple_no_long", n_long[0], 0);
        clear();

        // Disable ch0 during WAIT; level keeps tracking while disabled.
        button[0] = 1'b1; step(5);
        button[0] = 1'b0; step(10);
        enable[0] = 1'b0; step(5);
        button[0] = 1'b1; step(8);
        button[0] = 1'b0; step(17);
        enable[0] = 1'b1; step(10);
        chk("mask_no_single", n_single[0], 0);
        chk("mask_no_double", n_double[0], 0);
        chk("mask_level_rises", n_rise[0], 2);
        clear();

        // Reset during PRESS1 on ch1.
        button[1] = 1'b1; step(10);
        chk("midrst_level_hi", level, 4'h2);
        rst = 1'b1;
        button[1] = 1'b0;
        step(2);
        chk("midrst_level_clr", level, 0);
        chk("midrst_level_clr_nl", level_nl, 0);
        rst = 1'b0;
        step(60);
        chk("midrst_no_events", n_single[1] + n_double[1] + n_long[1], 0);
        chk("midrst_no_events_nl", n_single_nl[1] + n_double_nl[1], 0);

        chk("one_pulse_per_cycle", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
